// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control-bundle types for the RV32I pipelined control unit.
// Opcodes, ALU/immediate/result selects, stage bundles and the NOP bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND    = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR     = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLT    = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLL    = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL    = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRA    = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_PASS_B = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic             jalr;
        logic             alu_src_a;
        logic             alu_src_b;
        logic [1:0]       result_src;
        logic [ALU_W-1:0] alu_control;
        logic [2:0]       funct3;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_NOP = '0;
    localparam mem_ctrl_t MEM_NOP  = '0;
    localparam wb_ctrl_t  WB_NOP   = '0;

    // alt selects sub/sra; caller gates it for I-type so addi stays add
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3,
                                                     input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decode: instruction word to control bundle,
// immediate format select and illegal-instruction flag.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int EXT_ISA = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       bad;
    logic       ext_only;
    ctrl_t      c;
    logic [2:0] imm;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        c        = CTRL_NOP;
        imm      = IMM_I;
        bad      = 1'b0;
        ext_only = 1'b0;
        c.funct3 = funct3;
        case (opcode)
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.alu_src_b  = 1'b1;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
                imm         = IMM_S;
            end
            OP_R: begin
                c.reg_write   = 1'b1;
                c.alu_control = alu_from_f3(funct3, funct7[5]);
                bad = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 &&
                         (funct3 == 3'b000 || funct3 == 3'b101)));
                ext_only = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
            end
            OP_I: begin
                c.reg_write   = 1'b1;
                c.alu_src_b   = 1'b1;
                c.alu_control = alu_from_f3(funct3,
                                            funct3 == 3'b101 && funct7[5]);
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && funct7 != 7'b0000000 &&
                       funct7 != 7'b0100000);
                ext_only = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
            end
            OP_BRANCH: begin
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
                imm           = IMM_B;
                bad           = funct3 inside {3'b010, 3'b011};
                ext_only      = funct3 != 3'b000;
            end
            OP_JAL: begin
                c.jump       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                imm          = IMM_J;
            end
            OP_JALR: begin
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.alu_src_b  = 1'b1;
                bad          = funct3 != 3'b000;
                ext_only     = 1'b1;
            end
            OP_LUI: begin
                c.reg_write   = 1'b1;
                c.alu_src_b   = 1'b1;
                c.alu_control = ALU_PASS_B;
                imm           = IMM_U;
                ext_only      = 1'b1;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                imm         = IMM_U;
                ext_only    = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad || (ext_only && EXT_ISA == 0)) begin
            c   = CTRL_NOP;
            imm = IMM_I;
        end
    end

    assign ctrl    = c;
    assign imm_src = imm;
    assign illegal = bad || (ext_only && EXT_ISA == 0);

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: D-stage decode plus E/M/W control registers,
// E-stage flush, branch/jump redirect and saturating illegal counter.
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int EXT_ISA    = 1,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic                  reg_write_e,
    output logic                  mem_write_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  jalr_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic [1:0]            result_src_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  pc_src_e,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [CNT_W-1:0]      illegal_count
);

    ctrl_t     ctrl_d;
    ctrl_t     ctrl_e;
    mem_ctrl_t ctrl_m;
    wb_ctrl_t  ctrl_w;
    logic      take;

    ctrl_decoder #(.EXT_ISA(EXT_ISA)) u_dec (
        .instr   (instr_d),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (illegal_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e        <= CTRL_NOP;
            ctrl_m        <= MEM_NOP;
            ctrl_w        <= WB_NOP;
            illegal_count <= '0;
        end else begin
            ctrl_e            <= flush_e ? CTRL_NOP : ctrl_d;
            ctrl_m.reg_write  <= ctrl_e.reg_write;
            ctrl_m.mem_write  <= ctrl_e.mem_write;
            ctrl_m.result_src <= ctrl_e.result_src;
            ctrl_w.reg_write  <= ctrl_m.reg_write;
            ctrl_w.result_src <= ctrl_m.result_src;
            if (!flush_e && illegal_d && illegal_count != '1)
                illegal_count <= illegal_count + CNT_W'(1);
        end
    end

    always_comb begin
        take = 1'b0;
        case (ctrl_e.funct3)
            3'b000:  take = zero_e;
            3'b001:  take = !zero_e;
            3'b100:  take = lt_e;
            3'b101:  take = !lt_e;
            3'b110:  take = ltu_e;
            3'b111:  take = !ltu_e;
            default: take = 1'b0;
        endcase
    end

    assign pc_src_e      = ctrl_e.jump | (ctrl_e.branch & take);
    assign reg_write_e   = ctrl_e.reg_write;
    assign mem_write_e   = ctrl_e.mem_write;
    assign jump_e        = ctrl_e.jump;
    assign branch_e      = ctrl_e.branch;
    assign jalr_e        = ctrl_e.jalr;
    assign alu_src_a_e   = ctrl_e.alu_src_a;
    assign alu_src_b_e   = ctrl_e.alu_src_b;
    assign result_src_e  = ctrl_e.result_src;
    assign alu_control_e = ALU_CTRL_W'(ctrl_e.alu_control);
    assign reg_write_m   = ctrl_m.reg_write;
    assign mem_write_m   = ctrl_m.mem_write;
    assign result_src_m  = ctrl_m.result_src;
    assign reg_write_w   = ctrl_w.reg_write;
    assign result_src_w  = ctrl_w.result_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: mnemonic-level reference model, random and directed
// instruction streams, decoupled monitor comparing D/E/M/W and counter.
module tb_pipelined_control_unit;

    typedef struct packed {
        logic       illegal;
        logic [2:0] imm;
        logic       rw, mw, jump, branch, jalr, srca, srcb;
        logic [1:0] res;
        logic [3:0] alu;
        logic [1:0] bflag;
        logic       binv;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic fl;
    } item_t;

    localparam logic [31:0] NOP_I = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr_d = NOP_I;
    logic        flush_e = 1'b0;
    logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;
    logic [2:0]  imm_src_d;
    logic        illegal_d;
    logic        reg_write_e, mem_write_e, jump_e, branch_e, jalr_e;
    logic        alu_src_a_e, alu_src_b_e, pc_src_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_control_e;
    logic        reg_write_m, mem_write_m, reg_write_w;
    logic [1:0]  result_src_m, result_src_w;
    logic [7:0]  illegal_count;

    logic [31:0] instr_b = NOP_I;
    logic [2:0]  b_imm;
    logic        b_ill;
    logic        b_rwe, b_mwe, b_je, b_be, b_jre, b_sae, b_sbe, b_pc;
    logic [1:0]  b_rse, b_rsm, b_rsw;
    logic [3:0]  b_alu;
    logic        b_rwm, b_mwm, b_rww;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    item_t pend[$];
    exp_t  dq[$];
    exp_t  e_x, m_x, w_x;
    bit    e_v, m_v, w_v;
    int    cnt_x;

    always #5 clk = ~clk;

    pipelined_control_unit #(.EXT_ISA(1), .ALU_CTRL_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .flush_e(flush_e),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .jalr_e(jalr_e),
        .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .pc_src_e(pc_src_e), .reg_write_m(reg_write_m),
        .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w),
        .illegal_count(illegal_count)
    );

    pipelined_control_unit #(.EXT_ISA(0), .ALU_CTRL_W(4), .CNT_W(8)) dut_base (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_b), .flush_e(1'b0),
        .zero_e(1'b0), .lt_e(1'b0), .ltu_e(1'b0),
        .imm_src_d(b_imm), .illegal_d(b_ill),
        .reg_write_e(b_rwe), .mem_write_e(b_mwe),
        .jump_e(b_je), .branch_e(b_be), .jalr_e(b_jre),
        .alu_src_a_e(b_sae), .alu_src_b_e(b_sbe),
        .result_src_e(b_rse), .alu_control_e(b_alu),
        .pc_src_e(b_pc), .reg_write_m(b_rwm),
        .mem_write_m(b_mwm), .result_src_m(b_rsm),
        .reg_write_w(b_rww), .result_src_w(b_rsw),
        .illegal_count(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic string mnem(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        case (op)
            7'h03: return "lw";
            7'h23: return "sw";
            7'h33: begin
                if (f7 == 7'h20 && f3 == 3'd0) return "sub";
                if (f7 == 7'h20 && f3 == 3'd5) return "sra";
                if (f7 != 7'h00) return "";
                case (f3)
                    3'd0: return "add";
                    3'd1: return "sll";
                    3'd2: return "slt";
                    3'd3: return "sltu";
                    3'd4: return "xor";
                    3'd5: return "srl";
                    3'd6: return "or";
                    default: return "and";
                endcase
            end
            7'h13: begin
                case (f3)
                    3'd0: return "addi";
                    3'd1: return (f7 == 7'h00) ? "slli" : "";
                    3'd2: return "slti";
                    3'd3: return "sltiu";
                    3'd4: return "xori";
                    3'd5: return (f7 == 7'h00) ? "srli" :
                                 (f7 == 7'h20) ? "srai" : "";
                    3'd6: return "ori";
                    default: return "andi";
                endcase
            end
            7'h63: begin
                case (f3)
                    3'd0: return "beq";
                    3'd1: return "bne";
                    3'd4: return "blt";
                    3'd5: return "bge";
                    3'd6: return "bltu";
                    3'd7: return "bgeu";
                    default: return "";
                endcase
            end
            7'h6f: return "jal";
            7'h67: return (f3 == 3'd0) ? "jalr" : "";
            7'h37: return "lui";
            7'h17: return "auipc";
            default: return "";
        endcase
    endfunction

    function automatic bit is_base(input string m);
        case (m)
            "lw", "sw", "add", "sub", "and", "or", "slt",
            "addi", "andi", "ori", "slti", "beq", "jal": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input string m);
        case (m)
            "sub":           return 4'd1;
            "and", "andi":   return 4'd2;
            "or", "ori":     return 4'd3;
            "xor", "xori":   return 4'd4;
            "slt", "slti":   return 4'd5;
            "sltu", "sltiu": return 4'd6;
            "sll", "slli":   return 4'd7;
            "srl", "srli":   return 4'd8;
            "sra", "srai":   return 4'd9;
            default:         return 4'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input bit ext);
        exp_t  x;
        string m;
        x = '0;
        m = mnem(i);
        if (m == "" || (!ext && !is_base(m))) begin
            x.illegal = 1'b1;
            return x;
        end
        case (m)
            "lw": begin x.rw = 1; x.res = 2'd1; x.srcb = 1; end
            "sw": begin x.mw = 1; x.srcb = 1; x.imm = 3'd1; end
            "beq", "bne", "blt", "bge", "bltu", "bgeu": begin
                x.branch = 1;
                x.imm    = 3'd2;
                x.alu    = 4'd1;
                x.bflag  = (m == "beq" || m == "bne") ? 2'd0 :
                           (m == "blt" || m == "bge") ? 2'd1 : 2'd2;
                x.binv   = (m == "bne" || m == "bge" || m == "bgeu");
            end
            "jal": begin x.jump = 1; x.rw = 1; x.res = 2'd2; x.imm = 3'd3; end
            "jalr": begin
                x.jump = 1; x.jalr = 1; x.rw = 1; x.res = 2'd2; x.srcb = 1;
            end
            "lui": begin x.rw = 1; x.srcb = 1; x.alu = 4'd10; x.imm = 3'd4; end
            "auipc": begin
                x.rw = 1; x.srca = 1; x.srcb = 1; x.imm = 3'd4;
            end
            default: begin
                x.rw   = 1;
                x.srcb = (i[6:0] == 7'h13);
                x.alu  = alu_code(m);
            end
        endcase
        return x;
    endfunction

    function automatic logic exp_pc(input exp_t x);
        logic f;
        case (x.bflag)
            2'd0:    f = zero_e;
            2'd1:    f = lt_e;
            default: f = ltu_e;
        endcase
        return x.jump | (x.branch & (f ^ x.binv));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int          k;
        int          r;
        i = $urandom;
        k = $urandom_range(0, 11);
        r = $urandom_range(0, 3);
        case (k)
            0: begin i[6:0] = 7'h03; i[14:12] = 3'd2; end
            1: begin i[6:0] = 7'h23; i[14:12] = 3'd2; end
            2, 3: i[6:0] = 7'h33;
            4, 5: i[6:0] = 7'h13;
            6: i[6:0] = 7'h63;
            7: i[6:0] = 7'h6f;
            8: i[6:0] = 7'h67;
            9: i[6:0] = 7'h37;
            10: i[6:0] = 7'h17;
            default: i[1:0] = 2'($urandom_range(0, 2));
        endcase
        if (r < 2) i[31:25] = 7'h00;
        else if (r == 2) i[31:25] = 7'h20;
        return i;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic fl,
                         input logic [2:0] flags);
        item_t it;
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        instr_d = ins;
        flush_e = fl;
        {zero_e, lt_e, ltu_e} = flags;
        it.e  = model(ins, 1'b1);
        it.fl = fl;
        dq.push_back(it.e);
        pend.push_back(it);
    endtask

    task automatic reset_pulse(input int cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic model_clear();
        e_x = '0; m_x = '0; w_x = '0;
        e_v = 1; m_v = 1; w_v = 1;
        cnt_x = 0;
        pend.delete();
        dq.delete();
    endtask

    // monitor: advance the model at posedge, compare at negedge
    initial begin
        item_t it;
        exp_t  d;
        e_v = 0; m_v = 0; w_v = 0; cnt_x = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) model_clear();
            else begin
                w_x = m_x; w_v = m_v;
                m_x = e_x; m_v = e_v;
                if (pend.size() > 0) begin
                    it  = pend.pop_front();
                    e_x = it.fl ? '0 : it.e;
                    e_v = 1;
                    if (!it.fl && it.e.illegal && cnt_x < 255) cnt_x++;
                end else e_v = 0;
            end
            @(negedge clk);
            if (!rst_n) model_clear();
            if (dq.size() > 0) begin
                d = dq.pop_front();
                chk("illegal_d", 32'(illegal_d), 32'(d.illegal));
                chk("imm_src_d", 32'(imm_src_d), 32'(d.imm));
            end
            if (e_v) begin
                chk("e_bundle",
                    {reg_write_e, mem_write_e, jump_e, branch_e, jalr_e,
                     alu_src_a_e, alu_src_b_e, result_src_e, alu_control_e},
                    {e_x.rw, e_x.mw, e_x.jump, e_x.branch, e_x.jalr,
                     e_x.srca, e_x.srcb, e_x.res, e_x.alu});
                chk("pc_src_e", 32'(pc_src_e), 32'(exp_pc(e_x)));
            end
            if (m_v)
                chk("m_bundle", {reg_write_m, mem_write_m, result_src_m},
                    {m_x.rw, m_x.mw, m_x.res});
            if (w_v)
                chk("w_bundle", {reg_write_w, result_src_w},
                    {w_x.rw, w_x.res});
            chk("illegal_count", 32'(illegal_count), 32'(cnt_x));
        end
    end

    initial begin
        logic [31:0] blist[$];
        logic [31:0] x;
        exp_t        be;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);

        issue(32'h002081B3, 0, 3'($urandom));
        issue(32'h402081B3, 0, 3'($urandom));
        issue(32'h40000093, 0, 3'($urandom));
        issue(32'h00209463, 0, 3'($urandom));
        issue(NOP_I, 0, 3'b000);
        issue(32'h00209463, 0, 3'($urandom));
        issue(NOP_I, 0, 3'b100);
        issue(32'h0020F463, 0, 3'($urandom));
        issue(NOP_I, 0, 3'b001);
        issue(32'h0020A023, 1, 3'($urandom));
        issue(32'h0020A023, 0, 3'($urandom));
        issue(32'h00000000, 0, 3'($urandom));
        issue(32'h000010B7, 0, 3'($urandom));
        issue(32'h0000A083, 0, 3'($urandom));
        issue(NOP_I, 0, 3'($urandom));
        reset_pulse(2);

        repeat (300) issue(32'h00000000, 0, 3'($urandom));
        issue(NOP_I, 0, 3'($urandom));
        @(negedge clk);
        chk("cnt_saturated", 32'(illegal_count), 32'd255);

        reset_pulse(1);
        repeat (250)
            issue(rand_instr(), 1'($urandom_range(0, 9) == 0), 3'($urandom));
        reset_pulse(2);
        repeat (250)
            issue(rand_instr(), 1'($urandom_range(0, 9) == 0), 3'($urandom));
        repeat (4) issue(NOP_I, 0, 3'($urandom));
        repeat (2) @(negedge clk);

        blist = '{32'h000010B7, 32'h002081B3, 32'h402081B3, 32'h0020C1B3,
                  32'h00208463, 32'h00209463, 32'h0080006F, 32'h000080E7,
                  32'h40000093, 32'h00109093, 32'h0000A083, 32'h0020A023,
                  32'h00001097, 32'h0020A1B3, 32'h0020F1B3};
        repeat (40) blist.push_back(rand_instr());
        foreach (blist[k]) begin
            x       = blist[k];
            instr_b = x;
            #1;
            be = model(x, 1'b0);
            chk("base_illegal", 32'(b_ill), 32'(be.illegal));
            chk("base_imm_src", 32'(b_imm), 32'(be.imm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation RV32I control unit for the 5-stage pipeline. It decodes the D-stage instruction into a control bundle and carries that bundle through its own D→E, E→M and M→W registers. It resolves branch/jump redirect in E from ALU flags and flags illegal instructions. It supports E-stage flush and an optional extended RV32I subset selected by parameter.

Parameters:
EXT_ISA, 1, 1 = full RV32I ALU/branch/jump subset; 0 = base subset only (lw, sw, R add/sub/and/or/slt, addi/andi/ori/slti, beq, jal); everything else illegal.
ALU_CTRL_W, 4, width of alu_control; must be ≥4.
CNT_W, 8, width of saturating illegal-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_d  in  32  instruction in Decode
flush_e  in  1  load NOP bundle into E register next edge
zero_e  in  1  ALU result == 0
lt_e  in  1  signed rs1 < rs2
ltu_e  in  1  unsigned rs1 < rs2
imm_src_d  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational)
illegal_d  out  1  D-stage instruction illegal (combinational)
reg_write_e, mem_write_e, jump_e, branch_e, jalr_e, alu_src_a_e, alu_src_b_e  out  1 each  E-stage bundle
result_src_e  out  2  00 ALU, 01 mem, 10 pc+4
alu_control_e  out  ALU_CTRL_W  ALU op
pc_src_e  out  1  redirect fetch (combinational from E bundle + flags)
reg_write_m, mem_write_m  out  1  M-stage bundle
result_src_m  out  2
reg_write_w  out  1  W-stage bundle
result_src_w  out  2
illegal_count  out  CNT_W  saturating count of illegal instructions reaching E

Behaviour:
- Reset, asynchronous, rst_n=0: every registered output = 0 (NOP bundle) and illegal_count = 0, effective immediately. This applies mid-operation too. First capture is on the first rising edge after release.
- Latency: bundle visible in E 1 cycle after instr_d is sampled, in M after 2 cycles, in W after 3. M and W always advance; there is no stall input, and D stall is handled upstream by holding instr_d.
- flush_e=1: E register loads all-zero bundle, including the illegal bit. Flushed instructions never write regs or memory and are not counted.
- ALU encodings: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass_b.
- Sub is selected only for R-type (opcode 0110011) with funct3=000 and funct7=0100000. I-type funct3=000 is always add, whatever instr[30] holds.
- sra/srai when funct7[5]=1; otherwise srl/srli.
- Opcode decode:
  - lw: result 01, imm I, src_b imm.
  - sw: mem_write, imm S.
  - R-type: src_b reg.
  - I-ALU: src_b imm.
  - branch: branch=1, imm B, ALU sub.
  - jal: jump, result 10, imm J.
  - jalr (EXT): jump, jalr, result 10, imm I, ALU add.
  - lui (EXT): pass_b, imm U.
  - auipc (EXT): src_a=pc, add, imm U.
- Illegal conditions:
  - unlisted opcode, including 0x00000000;
  - R funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101};
  - slli funct7≠0; srli/srai funct7 ∉ {0000000, 0100000};
  - branch funct3 ∈ {010, 011}; jalr funct3≠000;
  - any EXT-only op when EXT_ISA=0.
- An illegal instruction produces the NOP bundle plus illegal_d=1. imm_src_d is don't-care (drive 000).
- Branch condition on branch_e, keyed by funct3 registered into E: beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu.
- pc_src_e = jump_e | (branch_e & cond).
- illegal_count increments when an unflushed illegal enters E and holds at 2^CNT_W−1 (no wrap).

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALU_*, IMM_*, RES_* encodings;
  - control-bundle struct/field widths and the NOP bundle constant.
- Sub-module ctrl_decoder holds the combinational D-stage decode (opcode/funct → bundle + illegal).
- pipelined_control_unit holds the three registers, flush, branch resolve and counter.

Test Plan:
- add x3,x1,x2 = 0x002081B3: alu_control_e=0000 and reg_write_e=1 at +1; reg_write_w=1 and result_src_w=00 at +3.
- sub 0x402081B3 → alu_control_e=0001. addi x1,x0,0x400 = 0x40000093 → alu_control_e=0000 and alu_src_b_e=1 (instr[30] regression).
- bne x1,x2,+8 = 0x00209463: imm_src_d=010. With zero_e=0, pc_src_e=1; with zero_e=1, pc_src_e=0. Repeat bgeu with ltu_e=1 → pc_src_e=0.
- sw 0x0020A023 with flush_e=1 at capture: mem_write_e=0 at +1 and mem_write_m=0 at +2. Without flush: mem_write_m=1 at +2.
- 0x00000000: illegal_d=1, E bundle all-zero, illegal_count=1 at +1. 300 consecutive illegals → count stops at 255. EXT_ISA=0 build with lui 0x000010B7 → illegal.
- rst_n low mid-stream with a lw in M: reg_write_m, result_src_m, reg_write_w and illegal_count all 0 before the next clk edge. They remain 0 until new instructions propagate.
